a2d_arbiter: RTL

Shares the single A2D converter interface between two requesters: requester 0 is the motion controller's IR sensor sequencer, requester 1 is a secondary sampler such as a battery or line-calibration monitor. The block captures one-cycle start pulses, arbitrates, and issues one conversion at a time to the A2D interface. It returns each result with a one-cycle completion pulse to the requester that asked for it, and aborts any conversion that stalls.

---
 rtl/a2d_arbiter_if.sv | 36 +++
 rtl/a2d_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/a2d_arbiter_if.sv
// Bus bundle between the A2D arbiter, its two requesters and the A2D converter.
// master = arbiter view, slave = requester/converter view.
interface a2d_arbiter_if #(
    parameter int CHNL_W = 3,
    parameter int RES_W  = 12
);
    logic              req0_strt;
    logic [CHNL_W-1:0] req0_chnnl;
    logic              req0_cmplt;
    logic [RES_W-1:0]  req0_res;
    logic              req0_busy;

    logic              req1_strt;
    logic [CHNL_W-1:0] req1_chnnl;
    logic              req1_cmplt;
    logic [RES_W-1:0]  req1_res;
    logic              req1_busy;

    logic              a2d_strt;
    logic [CHNL_W-1:0] a2d_chnnl;
    logic              a2d_cmplt;
    logic [RES_W-1:0]  a2d_res;
    logic              timeout_err;

    modport master (
        input  req0_strt, req0_chnnl, req1_strt, req1_chnnl, a2d_cmplt, a2d_res,
        output req0_cmplt, req0_res, req0_busy, req1_cmplt, req1_res, req1_busy,
        output a2d_strt, a2d_chnnl, timeout_err
    );

    modport slave (
        output req0_strt, req0_chnnl, req1_strt, req1_chnnl, a2d_cmplt, a2d_res,
        input  req0_cmplt, req0_res, req0_busy, req1_cmplt, req1_res, req1_busy,
        input  a2d_strt, a2d_chnnl, timeout_err
    );
endinterface

// File: rtl/a2d_arbiter.sv
// Two-requester arbiter for the single A2D converter, with stall timeout.
// Define A2D_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module a2d_arbiter #(
    parameter int CHNL_W  = 3,
    parameter int RES_W   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         rst_n,
    a2d_arbiter_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    pend_q, pend_d;
    logic [1:0][CHNL_W-1:0]        chnl_q, chnl_d;
    logic [1:0][RES_W-1:0]         res_q, res_d;
    logic [1:0]                    cmplt_q, cmplt_d;
    logic                          terr_q, terr_d;
    logic                          gnt_q, gnt_d;
    logic [TMR_W-1:0]              timer_q, timer_d;
    logic [CHNL_W-1:0]             a2d_chnnl_q, a2d_chnnl_d;
    logic                          winner;

`ifdef A2D_ARB_RR_EN
    logic                          ptr_q, ptr_d;

    // Pointer only breaks ties; a lone pending requester always wins.
    always_comb begin
        winner = pend_q[0] ? 1'b0 : 1'b1;
        if (pend_q == 2'b11) begin
            winner = ptr_q;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pend_q != 2'b00) begin
            ptr_d = ~winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        winner = pend_q[0] ? 1'b0 : 1'b1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        chnl_d      = chnl_q;
        res_d       = res_q;
        cmplt_d     = '0;
        terr_d      = 1'b0;
        gnt_d       = gnt_q;
        timer_d     = timer_q;
        a2d_chnnl_d = a2d_chnnl_q;

        // A start while already pending is dropped and keeps the first channel.
        if (bus.req0_strt && !pend_q[0]) begin
            pend_d[0] = 1'b1;
            chnl_d[0] = bus.req0_chnnl;
        end
        if (bus.req1_strt && !pend_q[1]) begin
            pend_d[1] = 1'b1;
            chnl_d[1] = bus.req1_chnnl;
        end

        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    gnt_d       = winner;
                    a2d_chnnl_d = chnl_q[winner];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.a2d_cmplt) begin
                    res_d[gnt_q]   = bus.a2d_res;
                    cmplt_d[gnt_q] = 1'b1;
                    pend_d[gnt_q]  = 1'b0;
                    state_d        = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    res_d[gnt_q]   = '0;
                    cmplt_d[gnt_q] = 1'b1;
                    terr_d         = 1'b1;
                    pend_d[gnt_q]  = 1'b0;
                    state_d        = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            chnl_q      <= '0;
            res_q       <= '0;
            cmplt_q     <= '0;
            terr_q      <= 1'b0;
            gnt_q       <= 1'b0;
            timer_q     <= '0;
            a2d_chnnl_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            chnl_q      <= chnl_d;
            res_q       <= res_d;
            cmplt_q     <= cmplt_d;
            terr_q      <= terr_d;
            gnt_q       <= gnt_d;
            timer_q     <= timer_d;
            a2d_chnnl_q <= a2d_chnnl_d;
        end
    end

    assign bus.a2d_strt    = (state_q == ISSUE);
    assign bus.a2d_chnnl   = a2d_chnnl_q;
    assign bus.timeout_err = terr_q;
    assign bus.req0_cmplt  = cmplt_q[0];
    assign bus.req0_res    = res_q[0];
    assign bus.req0_busy   = pend_q[0];
    assign bus.req1_cmplt  = cmplt_q[1];
    assign bus.req1_res    = res_q[1];
    assign bus.req1_busy   = pend_q[1];
endmodule
